// File: rtl/multicycle_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit_if
// Brief    : Decoder-to-control and control-to-datapath signal bundle.
// Revision : 1.0
// ============================================================================
interface multicycle_control_unit_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic [4:0]       func;
  logic [1:0]       reg_dest;
  logic             reg_write;
  logic             mem_read;
  logic             mem_write;
  logic [1:0]       mem_to_reg;
  logic             ALUsrc;
  logic [4:0]       ALUopsel;
  logic             ALUipsel;
  logic             JumpAddr;
  logic             isBranch;
  logic             LabelSel;
  logic             pc_write;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] instr_retired;

  modport master (
    input  opcode, func,
    output reg_dest, reg_write, mem_read, mem_write, mem_to_reg,
           ALUsrc, ALUopsel, ALUipsel, JumpAddr, isBranch, LabelSel,
           pc_write, halted, illegal, instr_retired
  );

  modport slave (
    output opcode, func,
    input  reg_dest, reg_write, mem_read, mem_write, mem_to_reg,
           ALUsrc, ALUopsel, ALUipsel, JumpAddr, isBranch, LabelSel,
           pc_write, halted, illegal, instr_retired
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit
// Brief    : FETCH/DECODE/EXEC/MEM/WB sequencer driving the miniRISC datapath.
// Revision : 1.0
// ============================================================================
module multicycle_control_unit #(
  parameter logic [4:0] ALU_ADD    = 5'b00000,
  parameter logic [4:0] ALU_PASS_A = 5'b01111,
  parameter int         CNT_W      = 32
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  multicycle_control_unit_if.master       bus
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_I    = 6'b000001;
  localparam logic [5:0] OP_LW   = 6'b000010;
  localparam logic [5:0] OP_SW   = 6'b000011;
  localparam logic [5:0] OP_B    = 6'b000100;
  localparam logic [5:0] OP_BC   = 6'b000101;
  localparam logic [5:0] OP_JR   = 6'b000110;
  localparam logic [5:0] OP_BL   = 6'b000111;
  localparam logic [5:0] OP_BCY  = 6'b001000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t           state, state_nx;
  logic [5:0]       op_q;
  logic [4:0]       func_q;
  logic [CNT_W-1:0] retired;

  logic [1:0] reg_dest, mem_to_reg;
  logic       reg_write, mem_read, mem_write, alu_src, jump_addr;
  logic       is_branch, label_sel, pc_write, halted, illegal;
  logic [4:0] alu_op;

  function automatic logic is_known(input logic [5:0] op);
    return (op <= OP_BCY) || (op == OP_HALT);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_FETCH;
      op_q   <= '0;
      func_q <= '0;
    end else begin
      state <= state_nx;
      if (state == S_DECODE) begin
        op_q   <= bus.opcode;
        func_q <= bus.func;
      end
    end
  end

  // Illegal opcodes retire as NOPs without counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      retired <= '0;
    else if (pc_write && !illegal)
      retired <= retired + CNT_W'(1);
  end

  always_comb begin
    state_nx   = state;
    reg_dest   = 2'b00;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 2'b00;
    alu_src    = 1'b0;
    alu_op     = 5'b00000;
    jump_addr  = 1'b0;
    is_branch  = 1'b0;
    label_sel  = 1'b0;
    pc_write   = 1'b0;
    halted     = 1'b0;
    illegal    = 1'b0;

    unique case (state)
      S_FETCH: state_nx = S_DECODE;

      // DECODE sees the live opcode; later phases use the latched copy.
      S_DECODE: begin
        if (bus.opcode == OP_HALT) begin
          state_nx = S_HALT;
        end else if (!is_known(bus.opcode)) begin
          pc_write = 1'b1;
          illegal  = 1'b1;
          state_nx = S_FETCH;
        end else begin
          state_nx = S_EXEC;
        end
      end

      S_EXEC: begin
        unique case (op_q)
          OP_R: begin
            alu_op   = func_q;
            state_nx = S_WB;
          end
          OP_I: begin
            alu_src  = 1'b1;
            alu_op   = func_q;
            state_nx = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src  = 1'b1;
            alu_op   = ALU_ADD;
            state_nx = S_MEM;
          end
          OP_B: begin
            is_branch = 1'b1;
            pc_write  = 1'b1;
            state_nx  = S_FETCH;
          end
          OP_BC, OP_BCY: begin
            is_branch = 1'b1;
            pc_write  = 1'b1;
            label_sel = 1'b1;
            alu_op    = func_q;
            state_nx  = S_FETCH;
          end
          OP_JR: begin
            is_branch = 1'b1;
            pc_write  = 1'b1;
            jump_addr = 1'b1;
            alu_op    = ALU_PASS_A;
            state_nx  = S_FETCH;
          end
          OP_BL: begin
            is_branch  = 1'b1;
            pc_write   = 1'b1;
            reg_write  = 1'b1;
            reg_dest   = 2'b10;
            mem_to_reg = 2'b00;
            state_nx   = S_FETCH;
          end
          default: state_nx = S_FETCH;
        endcase
      end

      S_MEM: begin
        alu_src = 1'b1;
        alu_op  = ALU_ADD;
        if (op_q == OP_LW) begin
          mem_read = 1'b1;
          state_nx = S_WB;
        end else begin
          mem_write = 1'b1;
          pc_write  = 1'b1;
          state_nx  = S_FETCH;
        end
      end

      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        state_nx  = S_FETCH;
        if (op_q == OP_LW) begin
          reg_dest   = 2'b01;
          mem_to_reg = 2'b01;
          mem_read   = 1'b1;
          alu_src    = 1'b1;
          alu_op     = ALU_ADD;
        end else begin
          reg_dest   = 2'b00;
          mem_to_reg = 2'b10;
          alu_src    = (op_q == OP_I);
          alu_op     = func_q;
        end
      end

      S_HALT: halted = 1'b1;

      default: state_nx = S_FETCH;
    endcase
  end

  assign bus.reg_dest      = reg_dest;
  assign bus.reg_write     = reg_write;
  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.mem_to_reg    = mem_to_reg;
  assign bus.ALUsrc        = alu_src;
  assign bus.ALUopsel      = alu_op;
  assign bus.ALUipsel      = 1'b0;
  assign bus.JumpAddr      = jump_addr;
  assign bus.isBranch      = is_branch;
  assign bus.LabelSel      = label_sel;
  assign bus.pc_write      = pc_write;
  assign bus.halted        = halted;
  assign bus.illegal       = illegal;
  assign bus.instr_retired = retired;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control_unit
// Brief    : Directed self-checking bench for multicycle_control_unit.
// Revision : 1.0
// ============================================================================
module tb_multicycle_control_unit;

  localparam int CNT_W = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;
  logic [CNT_W-1:0] cnt_exp;
  logic [19:0]      act;

  multicycle_control_unit_if #(.CNT_W(CNT_W)) bus ();

  multicycle_control_unit #(
    .ALU_ADD    (5'b00000),
    .ALU_PASS_A (5'b01111),
    .CNT_W      (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign act = {bus.reg_dest, bus.reg_write, bus.mem_read, bus.mem_write,
                bus.mem_to_reg, bus.ALUsrc, bus.ALUopsel, bus.ALUipsel,
                bus.JumpAddr, bus.isBranch, bus.LabelSel, bus.pc_write,
                bus.halted, bus.illegal};

  function automatic logic [19:0] mk(
    input logic [1:0] rd, input logic rw, input logic mr, input logic mw,
    input logic [1:0] m2r, input logic as, input logic [4:0] op,
    input logic ja, input logic ib, input logic ls, input logic pw,
    input logic hl, input logic il);
    return {rd, rw, mr, mw, m2r, as, op, 1'b0, ja, ib, ls, pw, hl, il};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.opcode = 6'd0;
    bus.func   = 5'd0;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (act !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", act, 20'd0);
    end
    n_cmp++;
    if (bus.instr_retired !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d expected 0", bus.instr_retired);
    end
    step();
    rst = 1'b0;
    cnt_exp = '0;
  endtask

  task automatic test_alu();
    logic [5:0]  ops [2];
    logic [4:0]  fns [2];
    logic [19:0] e [2][4];
    ops[0] = 6'b000000; fns[0] = 5'b00010;
    ops[1] = 6'b000001; fns[1] = 5'b00101;
    e[0][0] = '0; e[0][1] = '0;
    e[0][2] = mk(2'b00,0,0,0,2'b00,0,5'b00010,0,0,0,0,0,0);
    e[0][3] = mk(2'b00,1,0,0,2'b10,0,5'b00010,0,0,0,1,0,0);
    e[1][0] = '0; e[1][1] = '0;
    e[1][2] = mk(2'b00,0,0,0,2'b00,1,5'b00101,0,0,0,0,0,0);
    e[1][3] = mk(2'b00,1,0,0,2'b10,1,5'b00101,0,0,0,1,0,0);
    for (int i = 0; i < 2; i++) begin
      bus.opcode = ops[i];
      bus.func   = fns[i];
      for (int c = 0; c < 4; c++) begin
        n_cmp++;
        if (act !== e[i][c]) begin
          n_fail++;
          $display("FAIL alu op=%b cycle %0d: got %h expected %h", ops[i], c + 1, act, e[i][c]);
        end
        step();
      end
      cnt_exp++;
      n_cmp++;
      if (bus.instr_retired !== cnt_exp) begin
        n_fail++;
        $display("FAIL alu_count op=%b: got %0d expected %0d", ops[i], bus.instr_retired, cnt_exp);
      end
    end
  endtask

  task automatic test_mem();
    logic [19:0] e [2][5];
    logic [5:0]  ops [2];
    int          len [2];
    ops[0] = 6'b000010; len[0] = 5;
    ops[1] = 6'b000011; len[1] = 4;
    e[0][0] = '0; e[0][1] = '0;
    e[0][2] = mk(2'b00,0,0,0,2'b00,1,5'b00000,0,0,0,0,0,0);
    e[0][3] = mk(2'b00,0,1,0,2'b00,1,5'b00000,0,0,0,0,0,0);
    e[0][4] = mk(2'b01,1,1,0,2'b01,1,5'b00000,0,0,0,1,0,0);
    e[1][0] = '0; e[1][1] = '0;
    e[1][2] = mk(2'b00,0,0,0,2'b00,1,5'b00000,0,0,0,0,0,0);
    e[1][3] = mk(2'b00,0,0,1,2'b00,1,5'b00000,0,0,0,1,0,0);
    e[1][4] = '0;
    for (int i = 0; i < 2; i++) begin
      bus.opcode = ops[i];
      bus.func   = 5'b10101;
      for (int c = 0; c < len[i]; c++) begin
        n_cmp++;
        if (act !== e[i][c]) begin
          n_fail++;
          $display("FAIL mem op=%b cycle %0d: got %h expected %h", ops[i], c + 1, act, e[i][c]);
        end
        step();
      end
      cnt_exp++;
      n_cmp++;
      if (bus.instr_retired !== cnt_exp) begin
        n_fail++;
        $display("FAIL mem_count op=%b: got %0d expected %0d", ops[i], bus.instr_retired, cnt_exp);
      end
    end
  endtask

  task automatic test_branch(input int reps, input int first);
    logic [5:0]  ops [5];
    logic [4:0]  fns [5];
    logic [19:0] e3 [5];
    logic [19:0] exp_v;
    int          k;
    ops[0] = 6'b000100; fns[0] = 5'b00111;
    ops[1] = 6'b000101; fns[1] = 5'b00111;
    ops[2] = 6'b001000; fns[2] = 5'b01001;
    ops[3] = 6'b000110; fns[3] = 5'b00011;
    ops[4] = 6'b000111; fns[4] = 5'b00001;
    e3[0] = mk(2'b00,0,0,0,2'b00,0,5'b00000,0,1,0,1,0,0);
    e3[1] = mk(2'b00,0,0,0,2'b00,0,5'b00111,0,1,1,1,0,0);
    e3[2] = mk(2'b00,0,0,0,2'b00,0,5'b01001,0,1,1,1,0,0);
    e3[3] = mk(2'b00,0,0,0,2'b00,0,5'b01111,1,1,0,1,0,0);
    e3[4] = mk(2'b10,1,0,0,2'b00,0,5'b00000,0,1,0,1,0,0);
    for (int i = 0; i < reps; i++) begin
      k = (first < 0) ? i : first;
      bus.opcode = ops[k];
      bus.func   = fns[k];
      for (int c = 0; c < 3; c++) begin
        exp_v = (c == 2) ? e3[k] : 20'd0;
        n_cmp++;
        if (act !== exp_v) begin
          n_fail++;
          $display("FAIL branch op=%b cycle %0d: got %h expected %h", ops[k], c + 1, act, exp_v);
        end
        step();
      end
      cnt_exp++;
      n_cmp++;
      if (bus.instr_retired !== cnt_exp) begin
        n_fail++;
        $display("FAIL branch_count op=%b: got %0d expected %0d", ops[k], bus.instr_retired, cnt_exp);
      end
    end
  endtask

  task automatic test_illegal();
    logic [19:0] e2;
    e2 = mk(2'b00,0,0,0,2'b00,0,5'b00000,0,0,0,1,0,1);
    bus.opcode = 6'b101010;
    bus.func   = 5'b00000;
    n_cmp++;
    if (act !== 20'd0) begin
      n_fail++;
      $display("FAIL illegal cycle 1: got %h expected %h", act, 20'd0);
    end
    step();
    n_cmp++;
    if (act !== e2) begin
      n_fail++;
      $display("FAIL illegal cycle 2: got %h expected %h", act, e2);
    end
    step();
    n_cmp++;
    if (bus.instr_retired !== cnt_exp) begin
      n_fail++;
      $display("FAIL illegal_count: got %0d expected %0d", bus.instr_retired, cnt_exp);
    end
    n_cmp++;
    if (act !== 20'd0) begin
      n_fail++;
      $display("FAIL illegal_refetch: got %h expected %h", act, 20'd0);
    end
  endtask

  task automatic test_async_reset();
    bus.opcode = 6'b000011;
    bus.func   = 5'b00000;
    step(); step(); step();
    n_cmp++;
    if (bus.mem_write !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre_mem_write: got %b expected 1", bus.mem_write);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (act !== 20'd0) begin
      n_fail++;
      $display("FAIL async_outputs: got %h expected %h", act, 20'd0);
    end
    n_cmp++;
    if (bus.instr_retired !== 4'd0) begin
      n_fail++;
      $display("FAIL async_count: got %0d expected 0", bus.instr_retired);
    end
    step();
    rst = 1'b0;
    cnt_exp = '0;
    // A full-length b from here shows the FSM restarted in FETCH.
    test_branch(1, 0);
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    step();
    rst = 1'b0;
    cnt_exp = '0;
    test_branch(15, 0);
    n_cmp++;
    if (bus.instr_retired !== 4'd15) begin
      n_fail++;
      $display("FAIL wrap_full: got %0d expected 15", bus.instr_retired);
    end
    test_branch(1, 0);
    n_cmp++;
    if (bus.instr_retired !== 4'd0) begin
      n_fail++;
      $display("FAIL wrap_zero: got %0d expected 0", bus.instr_retired);
    end
  endtask

  task automatic test_halt();
    logic [19:0] eh;
    eh = mk(2'b00,0,0,0,2'b00,0,5'b00000,0,0,0,0,1,0);
    bus.opcode = 6'b111111;
    bus.func   = 5'b00000;
    step();
    n_cmp++;
    if (act !== 20'd0) begin
      n_fail++;
      $display("FAIL halt_decode: got %h expected %h", act, 20'd0);
    end
    step();
    bus.opcode = 6'b000000;
    for (int c = 0; c < 20; c++) begin
      n_cmp++;
      if (act !== eh) begin
        n_fail++;
        $display("FAIL halt cycle %0d: got %h expected %h", c + 3, act, eh);
      end
      step();
    end
    n_cmp++;
    if (bus.instr_retired !== cnt_exp) begin
      n_fail++;
      $display("FAIL halt_count: got %0d expected %0d", bus.instr_retired, cnt_exp);
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    cnt_exp = '0;
    test_reset();
    test_alu();
    test_mem();
    test_branch(5, -1);
    test_illegal();
    test_async_reset();
    test_wrap();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle control FSM directly upstream of the miniRISC datapath.
- Consumes the decoded `opcode`/`func` fields and sequences each instruction through FETCH, DECODE, EXEC, MEM and WB phases.
- Drives every datapath control input, plus a PC write-enable, a retired-instruction counter and halt/illegal status.

Parameters:
- ALU_ADD, 5'b00000, ALUopsel code issued for lw/sw address computation.
- ALU_PASS_A, 5'b01111, ALUopsel code issued for jr, so result = rs contents.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  opcode from the instruction decoder; valid from DECODE onward.
- func  in  5  function field from the instruction decoder.
- reg_dest  out  2  00=rs, 01=rt, 10=ra (r31).
- reg_write  out  1  register file write enable.
- mem_read  out  1  data memory read enable.
- mem_write  out  1  data memory write enable.
- mem_to_reg  out  2  00=nextPC, 01=memory data, 10=ALU result.
- ALUsrc  out  1  0=rt data, 1=sign-extended immediate.
- ALUopsel  out  5  ALU operation select.
- ALUipsel  out  1  ALU input select; always 0 in this design.
- JumpAddr  out  1  1=target from rs register.
- isBranch  out  1  instruction is a branch/jump.
- LabelSel  out  1  0=26-bit label, 1=16-bit label.
- pc_write  out  1  one-cycle PC update enable.
- halted  out  1  high while in HALT.
- illegal  out  1  one-cycle pulse on unknown opcode.
- instr_retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (asynchronous, any time, including mid-instruction):
  - state=FETCH, instr_retired=0, every output 0.
  - Opcode/func latch cleared to 0; no partial write completes.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT, encoded in 3 bits.
- Outputs are Moore, decoded from state plus opcode/func latched at end of DECODE.
- All outputs default to 0 in any state not listed below.
- Opcode classes:
  - 000000 R-type: rs <= rs op rt.
  - 000001 I-type ALU: rs <= rs op imm.
  - 000010 lw: rt <= M[rs+imm].
  - 000011 sw: M[rs+imm] <= rt.
  - 000100 b: 26-bit label.
  - 000101 conditional branch (bz/bnz/bltz): 16-bit label.
  - 000110 jr: jump to rs.
  - 000111 bl: branch and link to ra.
  - 001000 bcy/bncy: 16-bit label.
  - 111111 halt.
  - Anything else is illegal.
- FETCH: 1 cycle (synchronous instruction-memory latency) -> DECODE.
- DECODE: latch opcode/func, then:
  - halt -> HALT.
  - Illegal -> FETCH with pc_write=1, illegal=1 (NOP behaviour, counter unchanged).
  - Otherwise -> EXEC.
- EXEC by class:
  - R-type: ALUsrc=0, ALUopsel=func -> WB.
  - I-type: ALUsrc=1, ALUopsel=func -> WB.
  - lw/sw: ALUsrc=1, ALUopsel=ALU_ADD -> MEM.
  - Branch classes: isBranch=1, pc_write=1 -> FETCH.
    - b and bl: LabelSel=0.
    - Conditional and carry: LabelSel=1, ALUopsel=func (condition evaluated by the datapath).
    - jr: JumpAddr=1, ALUopsel=ALU_PASS_A.
  - bl additionally asserts reg_write=1, reg_dest=10, mem_to_reg=00 in the same cycle.
- MEM:
  - lw: mem_read=1, ALU controls held -> WB.
  - sw: mem_write=1, ALU controls held, pc_write=1 -> FETCH.
- WB: reg_write=1, pc_write=1 -> FETCH.
  - R-type/I-type: reg_dest=00, mem_to_reg=10.
  - lw: reg_dest=01, mem_to_reg=01, mem_read held at 1.
- Latency in cycles: R/I 4, lw 5, sw 4, branch/jump 3.
- instr_retired increments by 1 on every pc_write cycle except illegal; wraps from all-ones to 0.
- HALT: halted=1, all other outputs 0, pc_write never asserted; exits only via rst.
- reg_write and mem_write are never high in the same cycle.
- pc_write is high at most once per instruction.

Test Plan:
- Reset, then R-type opcode 000000, func 00010 -> pc_write high exactly cycle 4; reg_write=1, mem_to_reg=10, ALUopsel=00010 in WB; instr_retired=1.
- lw (000010) followed by sw (000011) -> lw: mem_read in cycles 4-5, reg_dest=01 in WB. sw: mem_write only in cycle 4, no reg_write. instr_retired=2 after 9 cycles.
- bl (000111) -> EXEC cycle 3: isBranch=1, reg_write=1, reg_dest=10, mem_to_reg=00, pc_write=1. jr -> JumpAddr=1, ALUopsel=01111.
- Opcode 101010 -> illegal and pc_write pulse in cycle 2; instr_retired unchanged. Then halt 111111 -> halted=1 steadily for 20 cycles, pc_write=0.
- Assert rst asynchronously mid-MEM of sw -> mem_write drops immediately without waiting for a clock edge; state FETCH; instr_retired=0.
- Preset counter via 2^CNT_W-1 retirements (force CNT_W=4 -> 15 instructions) -> next retirement gives 0.
